// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single RegFile write port among NUM_REQ writers,
// with a registered write stage and a pending-write scoreboard for RAW hazard detection.
module regfile_write_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   input  logic                        rsv_valid,
   input  logic [ADDR_W-1:0]           rsv_addr,
   input  logic [ADDR_W-1:0]           chk_addr1,
   input  logic [ADDR_W-1:0]           chk_addr2,
   output logic                        hazard1,
   output logic                        hazard2,
   output logic [(2**ADDR_W)-1:0]      pending
);

   localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned NUM_REGS = 2**ADDR_W;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0]    rrPtr;
   logic [PTR_W-1:0]    grantIdx;
   logic                grantValid;
   logic [ADDR_W-1:0]   grantAddr;
   logic [DATA_W-1:0]   grantData;
   logic [NUM_REGS-1:0] pendingNext;

   // Search from rrPtr with wrap-around; first valid requester wins. No grants during reset.
   always_comb begin
      int unsigned idx;
      grantValid = 1'b0;
      grantIdx   = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rrPtr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grantValid && req_valid[idx]) begin
            grantValid = 1'b1;
            grantIdx   = PTR_W'(idx);
         end
      end
      if (rst) grantValid = 1'b0;
   end

   always_comb begin
      req_ready = '0;
      if (grantValid) req_ready[grantIdx] = 1'b1;
   end

   always_comb begin
      grantAddr = '0;
      grantData = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grantIdx == PTR_W'(i)) begin
            grantAddr = req_addr[i*ADDR_W +: ADDR_W];
            grantData = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rrPtr <= '0;
      end else if (grantValid) begin
         rrPtr <= (grantIdx == LAST_IDX) ? '0 : grantIdx + PTR_W'(1);
      end
   end

   // Write stage: R0 grants are consumed but never reach the RegFile.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= grantValid && (grantAddr != '0);
         if (grantValid && (grantAddr != '0)) begin
            rf_waddr <= grantAddr;
            rf_wdata <= grantData;
         end
      end
   end

   // Set after clear so a same-edge reservation of the committing register stays outstanding.
   always_comb begin
      pendingNext = pending;
      if (rf_we) pendingNext[rf_waddr] = 1'b0;
      if (rsv_valid && (rsv_addr != '0)) pendingNext[rsv_addr] = 1'b1;
      pendingNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pendingNext;
   end

   // The write in the output stage is not yet visible in the RegFile, so it counts as outstanding.
   assign hazard1 = (chk_addr1 != '0) &&
                    (pending[chk_addr1] || (rf_we && (rf_waddr == chk_addr1)));
   assign hazard2 = (chk_addr2 != '0) &&
                    (pending[chk_addr2] || (rf_we && (rf_waddr == chk_addr2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, grants, fairness, R0 drop, scoreboard, reset mid-op.
module tb_regfile_write_arbiter;

   localparam int unsigned NUM_REQ = 3;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rf_we;
   logic [ADDR_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic                      rsv_valid;
   logic [ADDR_W-1:0]         rsv_addr;
   logic [ADDR_W-1:0]         chk_addr1;
   logic [ADDR_W-1:0]         chk_addr2;
   logic                      hazard1;
   logic                      hazard2;
   logic [(2**ADDR_W)-1:0]    pending;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .hazard1(hazard1), .hazard2(hazard2), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   logic [DATA_W-1:0] dataQ [NUM_REQ];
   logic [NUM_REQ-1:0] expGrant;
   int g;

   initial begin
      // T1: reset with every input busy
      rst = 1'b1;
      req_valid = 3'b111;
      setReq(0, 5'd1, 32'h1111_1111);
      setReq(1, 5'd2, 32'h2222_2222);
      setReq(2, 5'd3, 32'h3333_3333);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd4;
      chk_addr1 = 5'd0;
      chk_addr2 = 5'd0;
      #1;
      check("t1_ready_in_rst", 64'(req_ready), 64'(3'b000));
      tick();
      check("t1_rf_we", 64'(rf_we), 64'(1'b0));
      check("t1_rf_waddr", 64'(rf_waddr), 64'(5'd0));
      check("t1_rf_wdata", 64'(rf_wdata), 64'(32'h0));
      check("t1_pending", 64'(pending), 64'(32'h0));
      check("t1_ready", 64'(req_ready), 64'(3'b000));
      rst = 1'b0;
      req_valid = '0;
      rsv_valid = 1'b0;
      tick();
      check("t1_idle_we", 64'(rf_we), 64'(1'b0));

      // T2: single write from requester 1
      req_valid = 3'b010;
      setReq(1, 5'd5, 32'hDEAD_BEEF);
      #1;
      check("t2_ready", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0;
      check("t2_rf_we", 64'(rf_we), 64'(1'b1));
      check("t2_rf_waddr", 64'(rf_waddr), 64'(5'd5));
      check("t2_rf_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));
      check("t2_pending_unreserved", 64'(pending), 64'(32'h0));

      // T4: R0 write from requester 2 (rr_ptr is 2 here) is accepted then dropped
      req_valid = 3'b100;
      setReq(2, 5'd0, 32'h1);
      #1;
      check("t4_ready", 64'(req_ready), 64'(3'b100));
      tick();
      req_valid = '0;
      check("t4_rf_we", 64'(rf_we), 64'(1'b0));
      check("t4_pending", 64'(pending), 64'(32'h0));

      // T3: all three persistent; rr_ptr wrapped to 0 so grants go 0,1,2,0,1,2
      for (int i = 0; i < NUM_REQ; i++) begin
         dataQ[i] = 32'hA000_0000 + 32'(i * 16);
         setReq(i, 5'(10 + i), dataQ[i]);
      end
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         g = c % 3;
         expGrant = 3'b001 << g;
         #1;
         check("t3_grant", 64'(req_ready), 64'(expGrant));
         tick();
         check("t3_rf_we", 64'(rf_we), 64'(1'b1));
         check("t3_rf_waddr", 64'(rf_waddr), 64'(5'(10 + g)));
         check("t3_rf_wdata", 64'(rf_wdata), 64'(dataQ[g]));
         chk_addr2 = 5'(10 + g);
         #1;
         check("t3_hazard_bypass", 64'(hazard2), 64'(1'b1));
         // granted requester presents its next write
         dataQ[g] = dataQ[g] + 32'd1;
         setReq(g, 5'(10 + g), dataQ[g]);
      end
      req_valid = '0;
      chk_addr2 = 5'd0;
      tick();
      check("t3_idle_we", 64'(rf_we), 64'(1'b0));
      check("t3_hold_waddr", 64'(rf_waddr), 64'(5'd12));
      check("t3_hold_wdata", 64'(rf_wdata), 64'(32'hA000_0021));

      // T5: reserve r7, check hazard through commit
      rsv_valid = 1'b1;
      rsv_addr  = 5'd7;
      chk_addr1 = 5'd7;
      chk_addr2 = 5'd10;
      tick();
      rsv_valid = 1'b0;
      #1;
      check("t5_pending_set", 64'(pending), 64'(32'h80));
      check("t5_hazard1_rsv", 64'(hazard1), 64'(1'b1));
      check("t5_hazard2_clear", 64'(hazard2), 64'(1'b0));
      req_valid = 3'b001;
      setReq(0, 5'd7, 32'h77);
      #1;
      check("t5_ready", 64'(req_ready), 64'(3'b001));
      tick();
      req_valid = '0;
      check("t5_rf_we", 64'(rf_we), 64'(1'b1));
      check("t5_hazard1_we", 64'(hazard1), 64'(1'b1));
      tick();
      check("t5_hazard1_after", 64'(hazard1), 64'(1'b0));
      check("t5_pending_clear", 64'(pending), 64'(32'h0));
      // re-reserve and commit with a same-edge reservation
      rsv_valid = 1'b1;
      tick();
      rsv_valid = 1'b0;
      req_valid = 3'b010;
      setReq(1, 5'd7, 32'h78);
      #1;
      check("t5_ready2", 64'(req_ready), 64'(3'b010));
      tick();
      req_valid = '0;
      check("t5_rf_waddr2", 64'(rf_waddr), 64'(5'd7));
      rsv_valid = 1'b1;
      tick();
      rsv_valid = 1'b0;
      check("t5_set_wins", 64'(pending), 64'(32'h80));
      check("t5_hazard1_set_wins", 64'(hazard1), 64'(1'b1));

      // T6: grant r9 with rst high (rr_ptr is 2 before reset)
      chk_addr1 = 5'd9;
      rst = 1'b1;
      req_valid = 3'b001;
      setReq(0, 5'd9, 32'h99);
      rsv_valid = 1'b1;
      rsv_addr  = 5'd9;
      #1;
      check("t6_ready_in_rst", 64'(req_ready), 64'(3'b000));
      tick();
      rst = 1'b0;
      rsv_valid = 1'b0;
      check("t6_rf_we", 64'(rf_we), 64'(1'b0));
      check("t6_pending", 64'(pending), 64'(32'h0));
      check("t6_hazard1", 64'(hazard1), 64'(1'b0));
      req_valid = 3'b111;
      #1;
      check("t6_rr_ptr_zero", 64'(req_ready), 64'(3'b001));
      tick();
      req_valid = '0;
      check("t6_rf_we_after", 64'(rf_we), 64'(1'b1));
      check("t6_rf_waddr_after", 64'(rf_waddr), 64'(5'd9));
      check("t6_rf_wdata_after", 64'(rf_wdata), 64'(32'h99));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
